// File: rtl/mem_pipe_model_if.sv
// rtl/mem_pipe_model_if.sv - request/response signal bundle between a memory requester and mem_pipe_model
//
// Purpose: groups the mem_req/mem_resp handshake so the requester (master)
//          and the memory model (slave) share one connection.
// Signals:
//   mem_req_ready_o   memory can accept a request this cycle
//   mem_req_valid_i   request valid
//   mem_req_addr_i    byte address
//   mem_req_cmd_i     0=read, 1=write, other=nop
//   mem_req_typ_i     access size / signedness
//   mem_req_data_i    store data, right-aligned
//   mem_resp_valid_o  single-cycle response pulse
//   mem_resp_addr_o   echoed address
//   mem_resp_cmd_o    echoed cmd
//   mem_resp_typ_o    echoed typ
//   mem_resp_data_o   extended load data, 0 for writes and nops
`timescale 1ns/1ps
interface mem_pipe_model_if #(
  parameter int ADDR_W = 40,
  parameter int DATA_W = 64
);
  logic              mem_req_ready_o;
  logic              mem_req_valid_i;
  logic [ADDR_W-1:0] mem_req_addr_i;
  logic [4:0]        mem_req_cmd_i;
  logic [2:0]        mem_req_typ_i;
  logic [DATA_W-1:0] mem_req_data_i;
  logic              mem_resp_valid_o;
  logic [ADDR_W-1:0] mem_resp_addr_o;
  logic [4:0]        mem_resp_cmd_o;
  logic [2:0]        mem_resp_typ_o;
  logic [DATA_W-1:0] mem_resp_data_o;

  modport master (
    input  mem_req_ready_o,
    output mem_req_valid_i, mem_req_addr_i, mem_req_cmd_i, mem_req_typ_i, mem_req_data_i,
    input  mem_resp_valid_o, mem_resp_addr_o, mem_resp_cmd_o, mem_resp_typ_o, mem_resp_data_o
  );

  modport slave (
    output mem_req_ready_o,
    input  mem_req_valid_i, mem_req_addr_i, mem_req_cmd_i, mem_req_typ_i, mem_req_data_i,
    output mem_resp_valid_o, mem_resp_addr_o, mem_resp_cmd_o, mem_resp_typ_o, mem_resp_data_o
  );
endinterface

// File: rtl/mem_pipe_model.sv
// rtl/mem_pipe_model.sv - fixed-latency external memory model with outstanding window and typed sub-word access
//
// Purpose: word-organised memory answering every accepted request exactly
//          LATENCY cycles later, in order, with at most MAX_OUT requests
//          accepted but not yet answered.
// Ports:
//   clk    clock
//   reset  asynchronous active-low reset (memory contents are kept)
//   bus    mem_pipe_model_if slave side (request in, response out)
`timescale 1ns/1ps
module mem_pipe_model #(
  parameter int ADDR_W  = 40,
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4,
  parameter int MAX_OUT = 4
) (
  input  logic            clk,
  input  logic            reset,
  mem_pipe_model_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [4:0] CMD_RD = 5'd0;
  localparam logic [4:0] CMD_WR = 5'd1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [CNT_W-1:0]  count;
  logic              ready;
  logic              accept;
  logic              issue;

  logic [IDX_W-1:0]  idx;
  logic [2:0]        off;
  logic [5:0]        shift;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] raw;
  logic [DATA_W-1:0] sext;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] st_word;

  logic              pv    [LATENCY];
  logic [ADDR_W-1:0] paddr [LATENCY];
  logic [4:0]        pcmd  [LATENCY];
  logic [2:0]        ptyp  [LATENCY];
  logic [DATA_W-1:0] pdata [LATENCY];

  // Ready depends only on registered state, never on valid.
  assign ready               = (count < CNT_W'(MAX_OUT));
  assign accept              = bus.mem_req_valid_i & ready;
  assign bus.mem_req_ready_o = ready;

  // A request stops counting as outstanding on the edge that moves it into
  // the output stage, so a slot freed by a response can be reused in the
  // very cycle that response is shown.
  generate
    if (LATENCY == 1) begin : g_lat1
      assign issue = accept;
    end else begin : g_latn
      assign issue = pv[LATENCY-2];
    end
  endgenerate

  // typ[1:0] is log2 of the access size, typ[2] selects zero extension.
  always_comb begin
    idx       = bus.mem_req_addr_i[IDX_W+2:3];
    off       = bus.mem_req_addr_i[2:0];
    lane_mask = '1;
    case (bus.mem_req_typ_i[1:0])
      2'd0: lane_mask = 64'h0000_0000_0000_00FF;
      2'd1: begin
        off[0]    = 1'b0;
        lane_mask = 64'h0000_0000_0000_FFFF;
      end
      2'd2: begin
        off[1:0]  = 2'b00;
        lane_mask = 64'h0000_0000_FFFF_FFFF;
      end
      default: begin
        off       = 3'b000;
        lane_mask = '1;
      end
    endcase
    shift   = {off, 3'b000};
    rd_word = mem[idx];
    raw     = (rd_word >> shift) & lane_mask;
    case (bus.mem_req_typ_i[1:0])
      2'd0:    sext = {{56{raw[7]}},  raw[7:0]};
      2'd1:    sext = {{48{raw[15]}}, raw[15:0]};
      2'd2:    sext = {{32{raw[31]}}, raw[31:0]};
      default: sext = raw;
    endcase
    ld_data = bus.mem_req_typ_i[2] ? raw : sext;
    st_word = (rd_word & ~(lane_mask << shift)) |
              ((bus.mem_req_data_i & lane_mask) << shift);
  end

  // Memory has no reset so preloaded/committed contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && bus.mem_req_cmd_i == CMD_WR) begin
      mem[idx] <= st_word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pv[i]    <= 1'b0;
        paddr[i] <= '0;
        pcmd[i]  <= '0;
        ptyp[i]  <= '0;
        pdata[i] <= '0;
      end
    end else begin
      pv[0]    <= accept;
      paddr[0] <= accept ? bus.mem_req_addr_i : '0;
      pcmd[0]  <= accept ? bus.mem_req_cmd_i  : '0;
      ptyp[0]  <= accept ? bus.mem_req_typ_i  : '0;
      pdata[0] <= (accept && bus.mem_req_cmd_i == CMD_RD) ? ld_data : '0;
      for (int i = 1; i < LATENCY; i++) begin
        pv[i]    <= pv[i-1];
        paddr[i] <= paddr[i-1];
        pcmd[i]  <= pcmd[i-1];
        ptyp[i]  <= ptyp[i-1];
        pdata[i] <= pdata[i-1];
      end
      case ({accept, issue})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.mem_resp_valid_o = pv[LATENCY-1];
  assign bus.mem_resp_addr_o  = paddr[LATENCY-1];
  assign bus.mem_resp_cmd_o   = pcmd[LATENCY-1];
  assign bus.mem_resp_typ_o   = ptyp[LATENCY-1];
  assign bus.mem_resp_data_o  = pdata[LATENCY-1];
endmodule

// File: tb/tb_mem_pipe_model.sv
// tb/tb_mem_pipe_model.sv - self-checking bench for mem_pipe_model
`timescale 1ns/1ps
module tb_mem_pipe_model;
  localparam int LAT_A = 4;
  localparam int MAX_A = 4;
  localparam int LAT_B = 4;
  localparam int MAX_B = 2;
  localparam int DEPTH = 1024;
  localparam int MEM_BYTES = DEPTH * 8;
  localparam logic [4:0] RD = 5'd0;
  localparam logic [4:0] WR = 5'd1;

  typedef struct {
    int          cyc;
    logic [39:0] addr;
    logic [4:0]  cmd;
    logic [2:0]  typ;
    logic [63:0] data;
  } resp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   errors;
  int   checks;

  resp_t cap_a[$];
  resp_t exp_a[$];
  resp_t cap_b[$];
  logic [7:0] mb [MEM_BYTES];

  mem_pipe_model_if #(.ADDR_W(40), .DATA_W(64)) if_a ();
  mem_pipe_model_if #(.ADDR_W(40), .DATA_W(64)) if_b ();

  mem_pipe_model #(.ADDR_W(40), .DATA_W(64), .DEPTH(DEPTH), .LATENCY(LAT_A), .MAX_OUT(MAX_A))
    dut_a (.clk(clk), .reset(reset), .bus(if_a));
  mem_pipe_model #(.ADDR_W(40), .DATA_W(64), .DEPTH(DEPTH), .LATENCY(LAT_B), .MAX_OUT(MAX_B))
    dut_b (.clk(clk), .reset(reset), .bus(if_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (if_a.mem_resp_valid_o === 1'b1)
      cap_a.push_back('{cyc, if_a.mem_resp_addr_o, if_a.mem_resp_cmd_o, if_a.mem_resp_typ_o, if_a.mem_resp_data_o});
    if (if_b.mem_resp_valid_o === 1'b1)
      cap_b.push_back('{cyc, if_b.mem_resp_addr_o, if_b.mem_resp_cmd_o, if_b.mem_resp_typ_o, if_b.mem_resp_data_o});
  end

  // Byte-addressed reference memory: typ[1:0] is log2(size), typ[2] = unsigned.
  function automatic logic [63:0] model_load(input logic [39:0] a, input logic [2:0] t);
    int n = 1 << t[1:0];
    int base = int'(a % 40'(MEM_BYTES)) & ~(n - 1);
    logic [63:0] v = '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = mb[base + k];
    if (!t[2] && n < 8 && v[8*n-1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [39:0] a, input logic [2:0] t, input logic [63:0] d);
    int n = 1 << t[1:0];
    int base = int'(a % 40'(MEM_BYTES)) & ~(n - 1);
    for (int k = 0; k < n; k++) mb[base + k] = d[8*k +: 8];
  endtask

  task automatic send_a(input logic [39:0] a, input logic [4:0] c, input logic [2:0] t,
                        input logic [63:0] d, output int acc);
    int w = 0;
    @(negedge clk);
    if_a.mem_req_valid_i = 1'b1;
    if_a.mem_req_addr_i  = a;
    if_a.mem_req_cmd_i   = c;
    if_a.mem_req_typ_i   = t;
    if_a.mem_req_data_i  = d;
    while (if_a.mem_req_ready_o !== 1'b1 && w < 64) begin
      @(negedge clk);
      w++;
    end
    if (w >= 64) begin
      checks++;
      errors++;
      $display("FAIL send_ready_timeout: ready stayed low for %0d cycles, required 1", w);
      if_a.mem_req_valid_i = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    exp_a.push_back('{acc + LAT_A, a, c, t, (c == RD) ? model_load(a, t) : 64'd0});
    if (c == WR) model_store(a, t, d);
    @(posedge clk);
    #1;
    if_a.mem_req_valid_i = 1'b0;
  endtask

  task automatic wait_a(input int n, output bit ok);
    int w = 0;
    while (cap_a.size() < n && w < 200) begin
      @(negedge clk);
      w++;
    end
    ok = (cap_a.size() >= n);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (if_a.mem_req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_a: got %b want 1", if_a.mem_req_ready_o); end
    checks++; if (if_a.mem_resp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid_a: got %b want 0", if_a.mem_resp_valid_o); end
    checks++; if (if_a.mem_resp_addr_o !== 40'd0) begin errors++; $display("FAIL reset_addr_a: got %h want 0", if_a.mem_resp_addr_o); end
    checks++; if (if_a.mem_resp_cmd_o !== 5'd0 || if_a.mem_resp_typ_o !== 3'd0) begin errors++; $display("FAIL reset_cmd_typ_a: got %h/%h want 0/0", if_a.mem_resp_cmd_o, if_a.mem_resp_typ_o); end
    checks++; if (if_a.mem_resp_data_o !== 64'd0) begin errors++; $display("FAIL reset_data_a: got %h want 0", if_a.mem_resp_data_o); end
    checks++; if (if_b.mem_req_ready_o !== 1'b1 || if_b.mem_resp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_b: ready=%b valid=%b want 1/0", if_b.mem_req_ready_o, if_b.mem_resp_valid_o); end
  endtask

  task automatic test_basic_read();
    int acc; bit ok;
    cap_a.delete(); exp_a.delete();
    send_a(40'h0, WR, 3'd3, 64'h8877665544332211, acc);
    send_a(40'h0, RD, 3'd3, 64'd0, acc);
    wait_a(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got %0d responses want 2", cap_a.size()); return; end
    checks++; if (cap_a[0].cmd !== WR || cap_a[0].data !== 64'd0) begin errors++; $display("FAIL basic_write_resp: cmd=%0d data=%h want 1/0", cap_a[0].cmd, cap_a[0].data); end
    checks++; if (cap_a[1].cyc != acc + 4) begin errors++; $display("FAIL basic_latency: resp cycle %0d want %0d", cap_a[1].cyc, acc + 4); end
    checks++; if (cap_a[1].data !== 64'h8877665544332211) begin errors++; $display("FAIL basic_data: got %h want 8877665544332211", cap_a[1].data); end
    checks++; if (cap_a[1].cmd !== RD || cap_a[1].typ !== 3'd3) begin errors++; $display("FAIL basic_echo: cmd=%0d typ=%0d want 0/3", cap_a[1].cmd, cap_a[1].typ); end
  endtask

  task automatic test_sub_word();
    logic [39:0] addrs [7] = '{40'h7, 40'h7, 40'h3, 40'h6, 40'h5, 40'h4, 40'h3};
    logic [2:0]  typs  [7] = '{3'd0, 3'd4, 3'd5, 3'd1, 3'd2, 3'd6, 3'd7};
    logic [63:0] want  [7] = '{64'hFFFFFFFFFFFFFF88, 64'h88, 64'h4433, 64'hFFFFFFFFFFFF8877,
                               64'hFFFFFFFF88776655, 64'h0000000088776655, 64'h8877665544332211};
    int acc; bit ok;
    cap_a.delete(); exp_a.delete();
    for (int i = 0; i < 7; i++) send_a(addrs[i], RD, typs[i], 64'd0, acc);
    wait_a(7, ok);
    checks++; if (!ok) begin errors++; $display("FAIL subword_timeout: got %0d responses want 7", cap_a.size()); return; end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (cap_a[i].data !== want[i] || cap_a[i].addr !== addrs[i] || cap_a[i].typ !== typs[i])
        begin errors++; $display("FAIL subword_%0d: addr=%h typ=%0d data=%h want addr=%h typ=%0d data=%h", i, cap_a[i].addr, cap_a[i].typ, cap_a[i].data, addrs[i], typs[i], want[i]); end
    end
  endtask

  task automatic test_store_forward();
    int acc_w, acc_r; bit ok;
    cap_a.delete(); exp_a.delete();
    send_a(40'h4, WR, 3'd2, 64'hDEADBEEF, acc_w);
    send_a(40'h0, RD, 3'd3, 64'd0, acc_r);
    wait_a(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fwd_timeout: got %0d responses want 2", cap_a.size()); return; end
    checks++; if (acc_r != acc_w + 1) begin errors++; $display("FAIL fwd_back_to_back: read accepted at %0d want %0d", acc_r, acc_w + 1); end
    checks++; if (cap_a[0].cmd !== WR || cap_a[0].data !== 64'd0) begin errors++; $display("FAIL fwd_write_resp: cmd=%0d data=%h want 1/0", cap_a[0].cmd, cap_a[0].data); end
    checks++; if (cap_a[1].data !== 64'hDEADBEEF44332211) begin errors++; $display("FAIL fwd_data: got %h want DEADBEEF44332211", cap_a[1].data); end
  endtask

  task automatic test_wrap_nop();
    int acc; bit ok;
    cap_a.delete(); exp_a.delete();
    send_a(40'h2000, RD, 3'd3, 64'd0, acc);
    send_a(40'h0, 5'd5, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, acc);
    send_a(40'h0, RD, 3'd3, 64'd0, acc);
    wait_a(3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrapnop_timeout: got %0d responses want 3", cap_a.size()); return; end
    checks++; if (cap_a[0].data !== 64'hDEADBEEF44332211 || cap_a[0].addr !== 40'h2000) begin errors++; $display("FAIL wrap_alias: addr=%h data=%h want 2000/DEADBEEF44332211", cap_a[0].addr, cap_a[0].data); end
    checks++; if (cap_a[1].cmd !== 5'd5 || cap_a[1].data !== 64'd0) begin errors++; $display("FAIL nop_resp: cmd=%0d data=%h want 5/0", cap_a[1].cmd, cap_a[1].data); end
    checks++; if (cap_a[2].data !== 64'hDEADBEEF44332211) begin errors++; $display("FAIL nop_no_effect: got %h want DEADBEEF44332211", cap_a[2].data); end
  endtask

  task automatic test_back_to_back();
    int acc_q[$];
    int outst, k, obs_acc;
    bit rdy_exp;
    bit timed_out;
    int w;
    cap_b.delete();
    k = 0; obs_acc = 0;
    @(negedge clk);
    for (int c = 0; c < 14; c++) begin
      if_b.mem_req_valid_i = 1'b1;
      if_b.mem_req_addr_i  = 40'(k * 8);
      if_b.mem_req_cmd_i   = WR;
      if_b.mem_req_typ_i   = 3'd3;
      if_b.mem_req_data_i  = 64'(k);
      // Outstanding = accepted earlier whose response cycle has not yet arrived.
      outst = 0;
      foreach (acc_q[j]) if (acc_q[j] < cyc && acc_q[j] + LAT_B > cyc) outst++;
      rdy_exp = (outst < MAX_B);
      checks++; if (if_b.mem_req_ready_o !== rdy_exp) begin errors++; $display("FAIL b2b_ready_c%0d: got %b want %b", c, if_b.mem_req_ready_o, rdy_exp); end
      if (if_b.mem_req_ready_o === 1'b1) obs_acc++;
      if (rdy_exp) begin acc_q.push_back(cyc); k++; end
      @(negedge clk);
    end
    if_b.mem_req_valid_i = 1'b0;
    checks++; if (obs_acc != 8) begin errors++; $display("FAIL b2b_throughput: %0d accepts in 14 cycles want 8", obs_acc); end
    w = 0;
    while (cap_b.size() < acc_q.size() && w < 100) begin @(negedge clk); w++; end
    timed_out = (cap_b.size() < acc_q.size());
    checks++; if (timed_out) begin errors++; $display("FAIL b2b_timeout: got %0d responses want %0d", cap_b.size(), acc_q.size()); return; end
    for (int i = 0; i < acc_q.size(); i++) begin
      checks++;
      if (cap_b[i].cyc != acc_q[i] + LAT_B || cap_b[i].addr !== 40'(i * 8) || cap_b[i].cmd !== WR || cap_b[i].data !== 64'd0)
        begin errors++; $display("FAIL b2b_resp_%0d: cyc=%0d addr=%h cmd=%0d data=%h want cyc=%0d addr=%h cmd=1 data=0", i, cap_b[i].cyc, cap_b[i].addr, cap_b[i].cmd, cap_b[i].data, acc_q[i] + LAT_B, 40'(i * 8)); end
    end
  endtask

  task automatic test_random();
    int acc; bit ok; int r;
    logic [39:0] a; logic [4:0] c; logic [2:0] t; logic [63:0] d;
    cap_a.delete(); exp_a.delete();
    for (int w = 0; w < 16; w++) send_a(40'(w * 8), WR, 3'd3, {$urandom, $urandom}, acc);
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
      a = {$urandom, $urandom};
      a[12:7] = 6'd0;
      r = $urandom_range(0, 9);
      c = (r < 6) ? RD : (r < 9) ? WR : 5'($urandom_range(2, 31));
      t = 3'($urandom_range(0, 7));
      d = {$urandom, $urandom};
      send_a(a, c, t, d, acc);
    end
    wait_a(exp_a.size(), ok);
    repeat (LAT_A + 2) @(negedge clk);
    checks++; if (cap_a.size() != exp_a.size()) begin errors++; $display("FAIL rand_count: got %0d responses want %0d", cap_a.size(), exp_a.size()); return; end
    for (int i = 0; i < exp_a.size(); i++) begin
      checks++;
      if (cap_a[i].cyc != exp_a[i].cyc || cap_a[i].addr !== exp_a[i].addr || cap_a[i].cmd !== exp_a[i].cmd ||
          cap_a[i].typ !== exp_a[i].typ || cap_a[i].data !== exp_a[i].data)
        begin errors++; $display("FAIL rand_%0d: cyc=%0d addr=%h cmd=%0d typ=%0d data=%h want cyc=%0d addr=%h cmd=%0d typ=%0d data=%h", i, cap_a[i].cyc, cap_a[i].addr, cap_a[i].cmd, cap_a[i].typ, cap_a[i].data, exp_a[i].cyc, exp_a[i].addr, exp_a[i].cmd, exp_a[i].typ, exp_a[i].data); end
    end
  endtask

  task automatic test_reset_inflight();
    int acc; bit ok;
    cap_a.delete(); exp_a.delete();
    send_a(40'h40, WR, 3'd3, 64'h0123456789ABCDEF, acc);
    send_a(40'h48, RD, 3'd3, 64'd0, acc);
    send_a(40'h40, RD, 3'd3, 64'd0, acc);
    reset = 1'b0;
    #1;
    checks++; if (if_a.mem_resp_valid_o !== 1'b0 || if_a.mem_req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_async: valid=%b ready=%b want 0/1", if_a.mem_resp_valid_o, if_a.mem_req_ready_o); end
    cap_a.delete(); exp_a.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (cap_a.size() != 0) begin errors++; $display("FAIL rst_dropped: got %0d responses want 0", cap_a.size()); end
    checks++; if (if_a.mem_req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", if_a.mem_req_ready_o); end
    send_a(40'h40, RD, 3'd3, 64'd0, acc);
    wait_a(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_readback_timeout: got %0d responses want 1", cap_a.size()); return; end
    checks++; if (cap_a[0].data !== 64'h0123456789ABCDEF || cap_a[0].cyc != acc + LAT_A) begin errors++; $display("FAIL rst_readback: data=%h cyc=%0d want 0123456789ABCDEF cyc=%0d", cap_a[0].data, cap_a[0].cyc, acc + LAT_A); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < MEM_BYTES; i++) mb[i] = 8'h00;
    reset = 1'b0;
    if_a.mem_req_valid_i = 1'b0; if_a.mem_req_addr_i = '0; if_a.mem_req_cmd_i = '0;
    if_a.mem_req_typ_i = '0; if_a.mem_req_data_i = '0;
    if_b.mem_req_valid_i = 1'b0; if_b.mem_req_addr_i = '0; if_b.mem_req_cmd_i = '0;
    if_b.mem_req_typ_i = '0; if_b.mem_req_data_i = '0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    test_basic_read();
    test_sub_word();
    test_store_forward();
    test_wrap_nop();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
